// File: rtl/zap_dbg_pkg.sv
// Shared defaults and FSM state encoding for the ZAP register-file debug dumper.
package zap_dbg_pkg;

   localparam int NUM_REGS_DEF = 40;
   localparam int ADDR_W_DEF   = 6;
   localparam int DATA_W_DEF   = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      STREAM   = 2'd2,
      DONE     = 2'd3
   } dump_state_e;

endpackage

// File: rtl/zap_regfile_dumper.sv
// Freezes the pipeline, then walks registers first..last through one read port and
// streams each word with its index over a one-entry valid/ready output stage.
module zap_regfile_dumper
   import zap_dbg_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_first,
   input  logic [ADDR_W-1:0] i_last,
   input  logic              i_abort,
   output logic              o_freeze_req,
   input  logic              i_freeze_ack,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [ADDR_W-1:0] o_idx,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   localparam logic [ADDR_W:0] MAX_IDX = (ADDR_W+1)'(NUM_REGS - 1);

   dump_state_e       state_q, state_d;
   logic [ADDR_W:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              olast_q, olast_d;
   logic              err_q, err_d;

   logic range_ok;
   logic words_left;
   logic accept;

   assign range_ok   = (i_first <= i_last) && ({1'b0, i_last} <= MAX_IDX);
   // ptr carries one extra bit so it can step past last without wrapping.
   assign words_left = (ptr_q <= {1'b0, last_q});
   assign accept     = valid_q && i_ready;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      last_d  = last_q;
      valid_d = valid_q;
      data_d  = data_q;
      idx_d   = idx_q;
      olast_d = olast_q;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               if (range_ok) begin
                  last_d  = i_last;
                  ptr_d   = {1'b0, i_first};
                  state_d = WAIT_ACK;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         WAIT_ACK: begin
            if (i_freeze_ack) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (accept) begin
               valid_d = 1'b0;
            end
            if ((!valid_q || i_ready) && words_left) begin
               valid_d = 1'b1;
               data_d  = i_rd_data;
               idx_d   = ptr_q[ADDR_W-1:0];
               olast_d = (ptr_q == {1'b0, last_q});
               ptr_d   = ptr_q + 1'b1;
            end
            if (accept && olast_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Losing the freeze mid-stream invalidates the snapshot.
      if (state_q == STREAM && !i_freeze_ack) begin
         state_d = IDLE;
         valid_d = 1'b0;
         err_d   = 1'b1;
      end

      if (state_q != IDLE && i_abort) begin
         state_d = IDLE;
         valid_d = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         last_q  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
         olast_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         olast_q <= olast_d;
         err_q   <= err_d;
      end
   end

   assign o_freeze_req = (state_q != IDLE);
   assign o_busy       = (state_q != IDLE);
   assign o_done       = (state_q == DONE);
   assign o_rd_addr    = (state_q == STREAM) ? ptr_q[ADDR_W-1:0] : '0;
   assign o_valid      = valid_q;
   assign o_data       = data_q;
   assign o_idx        = idx_q;
   assign o_last       = olast_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_zap_regfile_dumper.sv
// Randomized scoreboard bench for zap_regfile_dumper: expected beats are queued when a
// dump is issued and popped by a monitor on every accepted beat.
module tb_zap_regfile_dumper;
   import zap_dbg_pkg::*;

   localparam int NR = 40;
   localparam int AW = 6;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_start = 1'b0;
   logic [AW-1:0] i_first = '0;
   logic [AW-1:0] i_last = '0;
   logic          i_abort = 1'b0;
   logic          o_freeze_req;
   logic          i_freeze_ack = 1'b0;
   logic [AW-1:0] o_rd_addr;
   logic [DW-1:0] i_rd_data;
   logic          o_valid;
   logic          i_ready = 1'b0;
   logic [DW-1:0] o_data;
   logic [AW-1:0] o_idx;
   logic          o_last;
   logic          o_busy;
   logic          o_done;
   logic          o_err;

   logic [DW-1:0] mem [NR];
   beat_t         exp_q[$];

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int acc_cnt = 0;
   int valid_cycles = 0;
   int rdy_mode = 0;    // 0 high, 1 toggle, 2 random, 3 low
   int ack_delay = 2;
   bit ack_kill = 1'b0;

   always #5 clk = ~clk;

   always_comb i_rd_data = (int'(o_rd_addr) < NR) ? mem[o_rd_addr] : '0;

   zap_regfile_dumper #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_start      (i_start),
      .i_first      (i_first),
      .i_last       (i_last),
      .i_abort      (i_abort),
      .o_freeze_req (o_freeze_req),
      .i_freeze_ack (i_freeze_ack),
      .o_rd_addr    (o_rd_addr),
      .i_rd_data    (i_rd_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_data       (o_data),
      .o_idx        (o_idx),
      .o_last       (o_last),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: a legal dump delivers every register of the range, in order.
   function automatic bit range_legal(input int f, input int l);
      return (f <= l) && (l < NR);
   endfunction

   task automatic push_range(input int f, input int l);
      beat_t b;
      for (int i = f; i <= l; i++) begin
         b.idx  = AW'(i);
         b.data = mem[i];
         b.last = (i == l);
         exp_q.push_back(b);
      end
   endtask

   // Sink ready generator
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       i_ready = 1'b1;
         1:       i_ready = ~i_ready;
         2:       i_ready = 1'($urandom_range(0, 1));
         default: i_ready = 1'b0;
      endcase
   end

   // Pipeline model: acknowledges freeze a few cycles after the request
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (ack_kill || !o_freeze_req) begin
            i_freeze_ack = 1'b0;
            cnt = 0;
         end else if (cnt >= ack_delay) begin
            i_freeze_ack = 1'b1;
         end else begin
            cnt++;
         end
      end
   end

   // Monitor
   initial begin
      beat_t cur, prev_beat, e;
      bit    prev_hold, prev_abort, prev_ack, prev_done, want_first;
      int    cyc, t_ack;
      prev_hold = 0; prev_abort = 0; prev_ack = 0; prev_done = 0; want_first = 0;
      cyc = 0; t_ack = 0;
      forever begin
         @(negedge clk);
         cyc++;
         cur = '{idx: o_idx, data: o_data, last: o_last};
         if (!rst_n) begin
            prev_hold = 0; prev_done = 0; want_first = 0; prev_ack = 0;
         end else begin
            if (o_valid) valid_cycles++;
            if (i_freeze_ack && !prev_ack) begin
               t_ack = cyc;
               want_first = 1;
            end
            if (want_first && o_valid) begin
               chk((cyc - t_ack) == 2, "first_valid_latency", 64'(cyc - t_ack), 64'd2);
               want_first = 0;
            end
            if (prev_hold && !prev_abort && prev_ack) begin
               chk(o_valid && (cur == prev_beat), "hold_stable", {o_valid, cur}, {1'b1, prev_beat});
            end
            if (o_valid && i_ready) begin
               acc_cnt++;
               chk(exp_q.size() > 0, "unexpected_beat", cur, 64'd0);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk(cur == e, "beat", cur, e);
               end
            end
            if (prev_done) begin
               chk(!o_freeze_req && !o_busy, "after_done", {o_freeze_req, o_busy}, 2'b00);
            end
            if (o_done) begin
               done_cnt++;
               chk(o_freeze_req && o_busy, "done_cycle", {o_freeze_req, o_busy}, 2'b11);
               chk(exp_q.size() == 0, "done_pending", 64'(exp_q.size()), 64'd0);
            end
            if (o_err) err_cnt++;
            prev_hold  = o_valid && !i_ready;
            prev_beat  = cur;
            prev_abort = i_abort;
            prev_ack   = i_freeze_ack;
            prev_done  = o_done;
         end
      end
   end

   task automatic start_dump(input int f, input int l);
      @(posedge clk);
      #1;
      i_first = AW'(f);
      i_last  = AW'(l);
      i_start = 1'b1;
      if (range_legal(f, l)) push_range(f, l);
      @(posedge clk);
      #1;
      i_start = 1'b0;
      @(negedge clk);
      if (range_legal(f, l)) begin
         chk(o_freeze_req && o_busy && !o_err, "start_freeze", {o_freeze_req, o_busy, o_err}, 3'b110);
      end else begin
         chk(o_err && !o_freeze_req && !o_busy, "bad_range_err", {o_err, o_freeze_req, o_busy}, 3'b100);
         @(negedge clk);
         chk(!o_err && !o_freeze_req && !o_busy, "bad_range_after", {o_err, o_freeze_req, o_busy}, 3'b000);
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (o_busy && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(!o_busy, name, 64'(n), 64'(budget));
   endtask

   task automatic run_good(input int f, input int l, input string name);
      int d0;
      d0 = done_cnt;
      start_dump(f, l);
      wait_idle(name, 1000);
      chk(done_cnt == d0 + 1, "done_count", 64'(done_cnt - d0), 64'd1);
      chk(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_beats(input int target, input string name);
      int n;
      n = 0;
      while (acc_cnt < target && n < 500) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk(acc_cnt >= target, name, 64'(acc_cnt), 64'(target));
   endtask

   task automatic chk_all_zero(input string name);
      logic [63:0] v;
      v = {o_valid, o_freeze_req, o_busy, o_done, o_err, o_last, o_idx, o_rd_addr};
      chk(v == 0 && o_data == 0, name, {v[31:0], o_data}, 64'd0);
   endtask

   initial begin
      int d0, e0, v0, a0;
      for (int i = 0; i < NR; i++) mem[i] = 32'hA500_0000 + 32'(i);

      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset_outputs");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Full dump at full throughput
      rdy_mode = 0;
      v0 = valid_cycles;
      a0 = acc_cnt;
      run_good(0, NR - 1, "full_dump_idle");
      chk(valid_cycles - v0 == NR, "full_valid_cycles", 64'(valid_cycles - v0), 64'(NR));
      chk(acc_cnt - a0 == NR, "full_beats", 64'(acc_cnt - a0), 64'(NR));

      for (int i = 0; i < NR; i++) mem[i] = $urandom;

      rdy_mode = 1;
      run_good(5, 8, "backpressure_idle");
      rdy_mode = 2;
      run_good(17, 17, "single_idle");

      e0 = err_cnt;
      d0 = done_cnt;
      start_dump(10, 3);
      start_dump(0, 40);
      chk(err_cnt - e0 == 2, "bad_range_errs", 64'(err_cnt - e0), 64'd2);
      chk(done_cnt == d0, "bad_range_no_done", 64'(done_cnt - d0), 64'd0);

      for (int k = 0; k < 6; k++) begin
         int f, l;
         f = $urandom_range(0, NR - 1);
         l = $urandom_range(f, NR - 1);
         rdy_mode = 2;
         ack_delay = $urandom_range(0, 4);
         run_good(f, l, "rand_dump_idle");
      end
      ack_delay = 2;

      // Abort after beat idx 2 has been accepted
      rdy_mode = 0;
      d0 = done_cnt;
      a0 = acc_cnt;
      start_dump(0, NR - 1);
      wait_beats(a0 + 3, "abort_wait_beats");
      i_abort = 1'b1;
      i_ready = 1'b0;
      rdy_mode = 3;
      @(posedge clk);
      #1 i_abort = 1'b0;
      @(negedge clk);
      chk(!o_valid && !o_freeze_req && !o_busy, "abort_state", {o_valid, o_freeze_req, o_busy}, 3'b000);
      exp_q.delete();
      repeat (4) @(negedge clk);
      chk(done_cnt == d0, "abort_no_done", 64'(done_cnt - d0), 64'd0);

      // Freeze acknowledge lost mid-stream
      rdy_mode = 2;
      d0 = done_cnt;
      a0 = acc_cnt;
      start_dump(0, NR - 1);
      wait_beats(a0 + 5, "ackloss_wait_beats");
      ack_kill = 1'b1;
      i_freeze_ack = 1'b0;
      i_ready = 1'b0;
      rdy_mode = 3;
      @(negedge clk);
      @(negedge clk);
      chk(o_err && !o_valid && !o_busy, "ackloss_err", {o_err, o_valid, o_busy}, 3'b100);
      exp_q.delete();
      ack_kill = 1'b0;
      repeat (3) @(negedge clk);
      chk(done_cnt == d0, "ackloss_no_done", 64'(done_cnt - d0), 64'd0);

      // Reset mid-stream, then a fresh dump
      rdy_mode = 0;
      a0 = acc_cnt;
      start_dump(0, NR - 1);
      wait_beats(a0 + 4, "reset_wait_beats");
      rst_n = 1'b0;
      #1 chk_all_zero("reset_midstream");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rdy_mode = 2;
      run_good(3, 9, "post_reset_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
